// File: rtl/act_mem_buffer_ctrl.sv
// N-buffer activation memory controller: fill/compute buffer mapping onto SRAM macros.
// Optional ACT_MEM_CLEAR_EN: zero the new fill buffer on every rotation.
module act_mem_buffer_ctrl #(
    parameter int N_DIM_ARRAY = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int TOTAL_SIZE  = 16384,
    parameter int N_BUFFERS   = 2,
    parameter int MACRO_WORDS = 2048,
    parameter int MACRO_WIDTH = 32,
    parameter int EXT_WIDTH   = 32,
    localparam int BUF_SIZE    = TOTAL_SIZE / N_BUFFERS,
    localparam int ADDR_W      = $clog2(BUF_SIZE),
    localparam int MACRO_BYTES = MACRO_WORDS * MACRO_WIDTH / 8,
    localparam int N_MACROS    = TOTAL_SIZE / MACRO_BYTES,
    localparam int ROW_W       = $clog2(MACRO_WORDS),
    localparam int IDX_W       = $clog2(N_BUFFERS)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            wr_valid_i,
    output logic                            wr_ready_o,
    input  logic [ADDR_W-1:0]               wr_addr_i,
    input  logic [EXT_WIDTH-1:0]            wr_data_i,
    input  logic [EXT_WIDTH/8-1:0]          wr_be_i,
    input  logic                            rd_valid_i,
    output logic                            rd_ready_o,
    input  logic [ADDR_W-1:0]               rd_addr_i,
    output logic [MACRO_WIDTH-1:0]          rd_data_o,
    output logic                            rd_data_valid_o,
    input  logic                            swap_req_i,
    output logic                            swap_ack_o,
    output logic [IDX_W-1:0]                fill_idx_o,
    output logic [IDX_W-1:0]                compute_idx_o,
    output logic [N_MACROS-1:0]             sram_a_cs_o,
    output logic                            sram_a_we_o,
    output logic [ROW_W-1:0]                sram_a_addr_o,
    output logic [MACRO_WIDTH-1:0]          sram_a_wdata_o,
    output logic [MACRO_WIDTH/8-1:0]        sram_a_bmask_o,
    output logic [N_MACROS-1:0]             sram_b_cs_o,
    output logic [ROW_W-1:0]                sram_b_addr_o,
    input  logic [N_MACROS*MACRO_WIDTH-1:0] sram_b_rdata_i
);
    localparam int MAC_W = (N_MACROS > 1) ? $clog2(N_MACROS) : 1;

    if (MACRO_WIDTH != N_DIM_ARRAY * DATA_WIDTH) begin : g_bad_width
        $error("MACRO_WIDTH must equal N_DIM_ARRAY*DATA_WIDTH");
    end
    if (EXT_WIDTH != MACRO_WIDTH) begin : g_bad_ext
        $error("EXT_WIDTH must equal MACRO_WIDTH");
    end
    if (BUF_SIZE % MACRO_BYTES != 0) begin : g_bad_buf
        $error("BUF_SIZE must be a multiple of MACRO_BYTES");
    end
    if (N_BUFFERS < 2) begin : g_bad_nbuf
        $error("N_BUFFERS must be at least 2");
    end

    typedef enum logic [2:0] {IDLE, DRAIN, ROTATE, CLEAR, ACK} state_t;

    state_t             state, state_nx;
    logic [IDX_W-1:0]   fill_idx, compute_idx;
    logic               rd_v1, rd_v2;
    logic [MAC_W-1:0]   rd_mac1, rd_mac2;
    logic               wr_fire, rd_fire;
    int                 wr_phys, rd_phys;

    function automatic int phys_of(input logic [IDX_W-1:0] idx,
                                   input logic [ADDR_W-1:0] addr);
        return int'(idx) * BUF_SIZE + int'(addr);
    endfunction

    function automatic logic [MAC_W-1:0] macro_of(input int phys);
        return MAC_W'(phys / MACRO_BYTES);
    endfunction

    function automatic logic [ROW_W-1:0] row_of(input int phys);
        return ROW_W'((phys % MACRO_BYTES) >> 2);
    endfunction

    function automatic logic [N_MACROS-1:0] sel_of(input logic [MAC_W-1:0] m);
        sel_of = '0;
        sel_of[m] = 1'b1;
    endfunction

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(N_BUFFERS - 1)) ? '0 : idx + 1'b1;
    endfunction

    assign wr_ready_o      = (state == IDLE);
    assign rd_ready_o      = (state == IDLE);
    assign wr_fire         = wr_valid_i && wr_ready_o;
    assign rd_fire         = rd_valid_i && rd_ready_o;
    assign wr_phys         = phys_of(fill_idx, wr_addr_i);
    assign rd_phys         = phys_of(compute_idx, rd_addr_i);
    assign swap_ack_o      = (state == ACK);
    assign fill_idx_o      = fill_idx;
    assign compute_idx_o   = compute_idx;
    assign rd_data_valid_o = rd_v2;
    assign rd_data_o       = sram_b_rdata_i[rd_mac2*MACRO_WIDTH +: MACRO_WIDTH];

`ifdef ACT_MEM_CLEAR_EN
    logic [ADDR_W-1:0] clr_addr;
    int                clr_phys;
    logic              clr_last;

    assign clr_phys = phys_of(fill_idx, clr_addr);
    assign clr_last = (clr_addr == ADDR_W'(BUF_SIZE - 4));
`endif

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:   if (swap_req_i) state_nx = DRAIN;
            // rd_v2 is already on rd_data_o, so only stage-1 reads block rotation
            DRAIN:  if (!rd_v1 && sram_a_cs_o == '0) state_nx = ROTATE;
`ifdef ACT_MEM_CLEAR_EN
            ROTATE: state_nx = CLEAR;
            CLEAR:  if (clr_last) state_nx = ACK;
`else
            ROTATE: state_nx = ACK;
            CLEAR:  state_nx = ACK;
`endif
            ACK:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            fill_idx       <= '0;
            compute_idx    <= IDX_W'(N_BUFFERS - 1);
            rd_v1          <= 1'b0;
            rd_v2          <= 1'b0;
            rd_mac1        <= '0;
            rd_mac2        <= '0;
            sram_a_cs_o    <= '0;
            sram_a_we_o    <= 1'b0;
            sram_a_addr_o  <= '0;
            sram_a_wdata_o <= '0;
            sram_a_bmask_o <= '0;
            sram_b_cs_o    <= '0;
            sram_b_addr_o  <= '0;
`ifdef ACT_MEM_CLEAR_EN
            clr_addr       <= '0;
`endif
        end else begin
            state       <= state_nx;
            rd_v1       <= rd_fire;
            rd_v2       <= rd_v1;
            rd_mac2     <= rd_mac1;
            sram_a_cs_o <= '0;
            sram_a_we_o <= 1'b0;
            sram_b_cs_o <= '0;
            if (wr_fire) begin
                sram_a_cs_o    <= sel_of(macro_of(wr_phys));
                sram_a_we_o    <= 1'b1;
                sram_a_addr_o  <= row_of(wr_phys);
                sram_a_wdata_o <= wr_data_i;
                sram_a_bmask_o <= wr_be_i;
            end
            if (rd_fire) begin
                sram_b_cs_o   <= sel_of(macro_of(rd_phys));
                sram_b_addr_o <= row_of(rd_phys);
                rd_mac1       <= macro_of(rd_phys);
            end
            if (state == ROTATE) begin
                fill_idx    <= next_idx(fill_idx);
                compute_idx <= next_idx(compute_idx);
            end
`ifdef ACT_MEM_CLEAR_EN
            if (state == CLEAR) begin
                sram_a_cs_o    <= sel_of(macro_of(clr_phys));
                sram_a_we_o    <= 1'b1;
                sram_a_addr_o  <= row_of(clr_phys);
                sram_a_wdata_o <= '0;
                sram_a_bmask_o <= '1;
                clr_addr       <= clr_addr + ADDR_W'(4);
            end else begin
                clr_addr <= '0;
            end
`endif
        end
    end
endmodule

// File: tb/tb_act_mem_buffer_ctrl.sv
// Directed bench for act_mem_buffer_ctrl with a two-macro SRAM model.
// Default build (ACT_MEM_CLEAR_EN undefined).
module tb_act_mem_buffer_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        wr_valid, wr_ready;
    logic [12:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        rd_valid, rd_ready;
    logic [12:0] rd_addr;
    logic [31:0] rd_data;
    logic        rd_data_valid;
    logic        swap_req, swap_ack;
    logic        fill_idx, compute_idx;
    logic [1:0]  a_cs;
    logic        a_we;
    logic [10:0] a_addr;
    logic [31:0] a_wdata;
    logic [3:0]  a_bmask;
    logic [1:0]  b_cs;
    logic [10:0] b_addr;
    logic [63:0] b_rdata;

    logic [31:0] mem [2][2048];
    logic [31:0] rdata [2];
    logic        mem_clr;

    int checks = 0;
    int errors = 0;
    bit seen;

    always #5 clk = ~clk;

    act_mem_buffer_ctrl dut (
        .clk(clk), .reset(reset),
        .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
        .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_be_i(wr_be),
        .rd_valid_i(rd_valid), .rd_ready_o(rd_ready),
        .rd_addr_i(rd_addr), .rd_data_o(rd_data),
        .rd_data_valid_o(rd_data_valid),
        .swap_req_i(swap_req), .swap_ack_o(swap_ack),
        .fill_idx_o(fill_idx), .compute_idx_o(compute_idx),
        .sram_a_cs_o(a_cs), .sram_a_we_o(a_we),
        .sram_a_addr_o(a_addr), .sram_a_wdata_o(a_wdata),
        .sram_a_bmask_o(a_bmask),
        .sram_b_cs_o(b_cs), .sram_b_addr_o(b_addr),
        .sram_b_rdata_i(b_rdata)
    );

    assign b_rdata = {rdata[1], rdata[0]};

    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (mem_clr) begin
                for (int r = 0; r < 2048; r++) mem[m][r] <= '0;
                rdata[m] <= '0;
            end else begin
                if (a_cs[m] && a_we)
                    for (int b = 0; b < 4; b++)
                        if (a_bmask[b]) mem[m][a_addr][8*b +: 8] <= a_wdata[8*b +: 8];
                if (b_cs[m]) rdata[m] <= mem[m][b_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [12:0] w_addr [3] = '{13'h0104, 13'h0108, 13'h010C};
    logic [31:0] w_data [3] = '{32'hDEADBEEF, 32'h11223344, 32'hFFFFFFFF};
    logic [3:0]  w_be   [3] = '{4'hF, 4'h5, 4'h0};
    logic [10:0] w_row  [3] = '{11'h041, 11'h042, 11'h043};
    logic [12:0] r_addr [3] = '{13'h0106, 13'h0108, 13'h010C};
    logic [31:0] r_exp  [3] = '{32'hDEADBEEF, 32'h00220044, 32'h00000000};

    initial begin
        reset = 1'b1; mem_clr = 1'b1;
        wr_valid = 0; wr_addr = '0; wr_data = '0; wr_be = '0;
        rd_valid = 0; rd_addr = '0; swap_req = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0; mem_clr = 1'b0;
        tick();
        check("rst_fill", 32'(fill_idx), 32'd0);
        check("rst_compute", 32'(compute_idx), 32'd1);
        check("rst_wr_ready", 32'(wr_ready), 32'd1);
        check("rst_rd_ready", 32'(rd_ready), 32'd1);
        check("rst_a_cs", 32'(a_cs), 32'd0);
        check("rst_b_cs", 32'(b_cs), 32'd0);
        check("rst_ack", 32'(swap_ack), 32'd0);
        check("rst_rvalid", 32'(rd_data_valid), 32'd0);

        // back-to-back writes into fill buffer 0 (macro 0)
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            wr_valid = 1; wr_addr = w_addr[i]; wr_data = w_data[i]; wr_be = w_be[i];
            tick();
            check("wr_cs", 32'(a_cs), 32'h1);
            check("wr_we", 32'(a_we), 32'h1);
            check("wr_row", 32'(a_addr), 32'(w_row[i]));
            check("wr_wdata", a_wdata, w_data[i]);
            check("wr_bmask", 32'(a_bmask), 32'(w_be[i]));
        end
        @(negedge clk);
        wr_valid = 0;
        tick();
        check("wr_cs_idle", 32'(a_cs), 32'h0);

        // swap: level request, drop on ack
        @(negedge clk);
        swap_req = 1;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            if (swap_ack) seen = 1;
        end
        check("swap1_ack_seen", 32'(seen), 32'd1);
        check("swap1_fill", 32'(fill_idx), 32'd1);
        check("swap1_compute", 32'(compute_idx), 32'd0);
        check("swap1_ready_ack", 32'(wr_ready), 32'd0);
        @(negedge clk);
        swap_req = 0;
        tick();
        check("swap1_ready_idle", 32'(rd_ready), 32'd1);
        check("swap1_ack_low", 32'(swap_ack), 32'd0);

        // pipelined reads of compute buffer 0
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rd_valid = 1; rd_addr = r_addr[i];
            tick();
            check("rd_b_cs", 32'(b_cs), 32'h1);
            check("rd_b_row", 32'(b_addr), 32'(w_row[i]));
            if (i > 0) begin
                check("rd_valid_pipe", 32'(rd_data_valid), 32'd1);
                check("rd_data_pipe", rd_data, r_exp[i-1]);
            end else begin
                check("rd_valid_first", 32'(rd_data_valid), 32'd0);
            end
        end
        @(negedge clk);
        rd_valid = 0;
        tick();
        check("rd_valid_last", 32'(rd_data_valid), 32'd1);
        check("rd_data_last", rd_data, r_exp[2]);
        tick();
        check("rd_valid_done", 32'(rd_data_valid), 32'd0);

        // write into fill buffer 1 lands in macro 1
        @(negedge clk);
        wr_valid = 1; wr_addr = 13'h0004; wr_data = 32'hCAFEF00D; wr_be = 4'hF;
        tick();
        check("wr1_cs", 32'(a_cs), 32'h2);
        check("wr1_row", 32'(a_addr), 32'h1);
        @(negedge clk);
        wr_valid = 0;

        // swap requested with two reads in flight
        @(negedge clk);
        rd_valid = 1; rd_addr = 13'h0104;
        @(posedge clk);
        @(negedge clk);
        rd_addr = 13'h0108; swap_req = 1;
        tick();
        rd_valid = 0;
        check("drain_wr_ready", 32'(wr_ready), 32'd0);
        check("drain_rd_ready", 32'(rd_ready), 32'd0);
        check("drain_d1_valid", 32'(rd_data_valid), 32'd1);
        check("drain_d1", rd_data, 32'hDEADBEEF);
        tick();
        check("drain_d2_valid", 32'(rd_data_valid), 32'd1);
        check("drain_d2", rd_data, 32'h00220044);
        tick();
        check("drain_rot_ack", 32'(swap_ack), 32'd0);
        check("drain_rot_valid", 32'(rd_data_valid), 32'd0);
        tick();
        check("drain_ack", 32'(swap_ack), 32'd1);
        check("drain_fill", 32'(fill_idx), 32'd0);
        check("drain_compute", 32'(compute_idx), 32'd1);
        @(negedge clk);
        swap_req = 0;
        tick();
        check("drain_idle_ready", 32'(rd_ready), 32'd1);

        // reset during DRAIN with a read in flight
        @(negedge clk);
        rd_valid = 1; rd_addr = 13'h0004; swap_req = 1;
        tick();
        rd_valid = 0; swap_req = 0;
        check("rstd_b_cs", 32'(b_cs), 32'h2);
        check("rstd_in_drain", 32'(rd_ready), 32'd0);
        @(negedge clk);
        reset = 1;
        tick();
        check("rstd_no_valid", 32'(rd_data_valid), 32'd0);
        @(negedge clk);
        reset = 0;
        tick();
        check("rstd_no_valid2", 32'(rd_data_valid), 32'd0);
        check("rstd_fill", 32'(fill_idx), 32'd0);
        check("rstd_compute", 32'(compute_idx), 32'd1);
        check("rstd_ready", 32'(rd_ready), 32'd1);
        check("rstd_ack", 32'(swap_ack), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
